adder_arb: RTL

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/adder_arb.sv
// Round-robin arbiter sharing one external N-bit adder among four requesters.
// Optional build macro ADDER_ARB_SAT_EN: saturate signed overflow instead of wrapping.
module adder_arb #(
    parameter int N       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req_valid,
    output logic [3:0]     req_ready,
    input  logic [4*N-1:0] req_dataL,
    input  logic [4*N-1:0] req_dataR,
    output logic [N-1:0]   add_L,
    output logic [N-1:0]   add_R,
    input  logic [N:0]     add_sum,
    output logic           rsp_valid,
    output logic [1:0]     rsp_id,
    output logic [N:0]     rsp_sum,
    input  logic           rsp_ready,
    output logic           rsp_stall
);

    localparam int             CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [N-1:0]    add_l_q, add_l_d;
    logic [N-1:0]    add_r_q, add_r_d;
    logic [1:0]      id_q, id_d;
    logic [N:0]      sum_q, sum_d;
    logic            vld_q, vld_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic [1:0]      idx;

`ifdef ADDER_ARB_SAT_EN
    function automatic logic [N:0] sat_sum(input logic [N-1:0] l, input logic [N-1:0] r,
                                           input logic [N:0] s);
        if (l[N-1] == r[N-1] && s[N-1] != l[N-1])
            return l[N-1] ? {2'b11, {(N-1){1'b0}}} : {2'b00, {(N-1){1'b1}}};
        return s;
    endfunction
`endif

    // Descending scan so the requester closest to ptr (offset 0) wins last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        idx       = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign req_ready = (state_q == IDLE && !rst && grant_vld) ? (4'b0001 << grant_idx) : 4'b0000;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        add_l_d = add_l_q;
        add_r_d = add_r_q;
        id_d    = id_q;
        sum_d   = sum_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    add_l_d = req_dataL[grant_idx*N +: N];
                    add_r_d = req_dataR[grant_idx*N +: N];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx + 2'd1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
`ifdef ADDER_ARB_SAT_EN
                sum_d   = sat_sum(add_l_q, add_r_q, add_sum);
`else
                sum_d   = add_sum;
`endif
                vld_d   = 1'b1;
                cnt_d   = '0;
                state_d = RESP;
            end
            RESP: begin
                if (cnt_q != TMO)
                    cnt_d = cnt_q + 1'b1;
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            add_l_q <= '0;
            add_r_q <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            add_l_q <= add_l_d;
            add_r_q <= add_r_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign add_L     = add_l_q;
    assign add_R     = add_r_q;
    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_stall = (state_q == RESP) && (cnt_q >= TMO);

endmodule
